// File: rtl/peripheral_uart_rx_pkg.sv
// Shared definitions for the J1 UART receiver: register offsets, decoder
// constant, FSM states and the oversampling divider helper.
package peripheral_uart_rx_pkg;

    localparam logic [3:0] RX_DATA    = 4'h0;
    localparam logic [3:0] RX_STAT    = 4'h2;
    localparam logic [3:0] RX_CTRL    = 4'h4;
    localparam logic [7:0] CS_UART_RX = 8'h6A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } rx_state_e;

    // Clocks per 1/16-bit tick; integer division, residual phase error is absorbed
    // by sampling near the bit centre.
    function automatic int unsigned tick_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / (baud * 16);
    endfunction

endpackage

// File: rtl/peripheral_uart_rx_core.sv
// Receive datapath: 2-FF synchroniser, free-running 16x tick divider and the
// 8N1 deframing FSM. Emits one-clock byte/framing-error strobes.
module peripheral_uart_rx_core #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       ferr_stb
);
    import peripheral_uart_rx_pkg::*;

    localparam int unsigned DIV = tick_div(CLK_FREQ, BAUD);
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic          rx_meta, rx_s;
    logic [DW-1:0] div_cnt;
    logic          tick;

    rx_state_e     state, state_nx;
    logic [3:0]    tcnt, tcnt_nx;
    logic [2:0]    bit_idx, bit_nx;
    logic [7:0]    shreg, shreg_nx;

    assign tick    = (div_cnt == DW'(DIV - 1));
    assign rx_byte = shreg;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others; blocking here would chain them.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            div_cnt <= '0;
            state   <= ST_IDLE;
            tcnt    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            state   <= state_nx;
            tcnt    <= tcnt_nx;
            bit_idx <= bit_nx;
            shreg   <= shreg_nx;
        end
    end

    // NOTE: every output of this block gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt;
        bit_nx   = bit_idx;
        shreg_nx = shreg;
        byte_stb = 1'b0;
        ferr_stb = 1'b0;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_nx = ST_START;
                        tcnt_nx  = '0;
                    end
                end
                ST_START: begin
                    // Seventh tick after the falling edge lands mid start bit.
                    if (tcnt == 4'd6) begin
                        tcnt_nx  = '0;
                        bit_nx   = '0;
                        state_nx = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tcnt_nx = tcnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (tcnt == 4'd15) begin
                        tcnt_nx  = '0;
                        shreg_nx = {rx_s, shreg[7:1]};
                        bit_nx   = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state_nx = ST_STOP;
                    end else begin
                        tcnt_nx = tcnt + 4'd1;
                    end
                end
                ST_STOP: begin
                    if (tcnt == 4'd15) begin
                        tcnt_nx = '0;
                        if (rx_s) begin
                            byte_stb = 1'b1;
                            state_nx = ST_IDLE;
                        end else begin
                            ferr_stb = 1'b1;
                            state_nx = ST_BRK;
                        end
                    end else begin
                        tcnt_nx = tcnt + 4'd1;
                    end
                end
                ST_BRK: begin
                    if (rx_s) state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/peripheral_uart_rx.sv
// J1 I/O-bus UART receiver: receive FIFO, sticky error flags and the
// data/status/control register mux around the deframing core.
module peripheral_uart_rx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        uart_rx,
    output logic        rx_irq
);
    import peripheral_uart_rx_pkg::*;

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]    rx_byte;
    logic          byte_stb, ferr_stb;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [2:0]    cnt3;
    logic          empty, full, pop, do_push, ovr_set;
    logic          ferr, ovr, clr_ferr, clr_ovr;
    logic          unused_d_in;

    peripheral_uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .rx_byte  (rx_byte),
        .byte_stb (byte_stb),
        .ferr_stb (ferr_stb)
    );

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = cs & rd & (addr == RX_DATA) & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign do_push  = byte_stb & (~full | pop);
    assign ovr_set  = byte_stb & full & ~pop;
    assign clr_ferr = cs & wr & (addr == RX_CTRL) & d_in[0];
    assign clr_ovr  = cs & wr & (addr == RX_CTRL) & d_in[1];
    assign cnt3     = 3'(count);
    assign rx_irq   = ~empty;
    assign unused_d_in = ^d_in[15:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ferr   <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Set wins over a simultaneous clear.
            ferr <= ferr_stb | (ferr & ~clr_ferr);
            ovr  <= ovr_set  | (ovr  & ~clr_ovr);
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone
    // define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= rx_byte;
    end

    always_comb begin
        d_out = '0;
        if (cs) begin
            case (addr)
                RX_DATA: if (!empty) d_out = {7'b0, 1'b1, mem[rd_ptr]};
                RX_STAT: d_out = {10'b0, cnt3, ovr, ferr, ~empty};
                default: d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_uart_rx.sv
// Directed bench for the J1 UART receiver at 50 MHz / 115200 baud (432 clk/bit).
module tb_peripheral_uart_rx;

    localparam int BIT_CLKS = 432;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_in;
    logic        cs, rd, wr;
    logic [3:0]  addr;
    logic [15:0] d_out;
    logic        uart_rx;
    logic        rx_irq;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    peripheral_uart_rx #(
        .CLK_FREQ   (50_000_000),
        .BAUD       (115200),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d_in    (d_in),
        .cs      (cs),
        .addr    (addr),
        .rd      (rd),
        .wr      (wr),
        .d_out   (d_out),
        .uart_rx (uart_rx),
        .rx_irq  (rx_irq)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_clks(BIT_CLKS);
        end
        uart_rx = stop_bit;
        wait_clks(BIT_CLKS);
        uart_rx = 1'b1;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [15:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1 d = d_out;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; addr = 4'h0;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [15:0] v);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0;
    endtask

    initial begin
        repeat (120000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] d;
        int          p4;
        bit          found;

        rst = 1'b1; d_in = '0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; uart_rx = 1'b1;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(4);

        // Reset state
        bus_rd(4'h2, d);  check("rst_stat", d, 16'h0000);
        check("rst_irq", {15'b0, rx_irq}, 16'h0000);
        bus_rd(4'h0, d);  check("rst_data_empty", d, 16'h0000);

        // 1: single byte
        send_frame(8'hA5, 1'b1);
        wait_clks(8);
        bus_rd(4'h2, d);  check("t1_stat", d, 16'h0009);
        check("t1_irq", {15'b0, rx_irq}, 16'h0001);
        addr = 4'h0; #1 check("t1_cs_low", d_out, 16'h0000);
        bus_rd(4'h0, d);  check("t1_data", d, 16'h01A5);
        bus_rd(4'h2, d);  check("t1_stat_after", d, 16'h0000);
        check("t1_irq_after", {15'b0, rx_irq}, 16'h0000);

        // 2: short low glitch
        uart_rx = 1'b0; wait_clks(4 * 27); uart_rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        bus_rd(4'h2, d);  check("t2_glitch", d, 16'h0000);

        // 3: framing error, ignored write offset, then clear
        send_frame(8'h3C, 1'b0);
        wait_clks(BIT_CLKS);
        bus_rd(4'h2, d);  check("t3_ferr", d, 16'h0002);
        bus_wr(4'h6, 16'h0003);
        bus_rd(4'h2, d);  check("t3_wr_other", d, 16'h0002);
        bus_wr(4'h4, 16'h0001);
        bus_rd(4'h2, d);  check("t3_clr", d, 16'h0000);

        // 4: overrun
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        wait_clks(8);
        bus_rd(4'h2, d);  check("t4_stat", d, 16'h0025);
        for (int b = 1; b <= 4; b++) begin
            bus_rd(4'h0, d); check($sformatf("t4_rd%0d", b), d, 16'h0100 | 16'(b));
        end
        bus_rd(4'h0, d);  check("t4_rd_empty", d, 16'h0000);
        bus_rd(4'h2, d);  check("t4_stat_ovr", d, 16'h0004);

        // 5: reset mid-frame (in the stop bit, before its mid-point sample)
        fork
            send_frame(8'h77, 1'b1);
            begin
                wait_clks(9 * BIT_CLKS + 50);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        wait_clks(BIT_CLKS);
        bus_rd(4'h2, d);  check("t5_stat_rst", d, 16'h0000);
        check("t5_irq_rst", {15'b0, rx_irq}, 16'h0000);
        send_frame(8'h55, 1'b1);
        wait_clks(8);
        bus_rd(4'h0, d);  check("t5_data", d, 16'h0155);

        // 6: pop aligned with the push into a full FIFO
        wait_clks(BIT_CLKS);
        found = 1'b0;
        p4 = 0;
        fork
            for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
            begin
                cs = 1'b1; rd = 1'b1; addr = 4'h2;
                for (int i = 0; i < 5 * FRAME_CLKS && !found; i++) begin
                    @(negedge clk);
                    #1;
                    if (d_out[5:3] == 3'd4) begin
                        found = 1'b1;
                        p4 = cyc;
                    end
                end
                cs = 1'b0; rd = 1'b0;
                check("t6_sync", {15'b0, found}, 16'h0001);
                if (found) begin
                    while (cyc < p4 + FRAME_CLKS - 1) @(negedge clk);
                    bus_rd(4'h0, d); check("t6_rd_at_push", d, 16'h0101);
                end
            end
        join
        wait_clks(8);
        bus_rd(4'h2, d);  check("t6_stat", d, 16'h0021);
        for (int b = 2; b <= 5; b++) begin
            bus_rd(4'h0, d); check($sformatf("t6_rd%0d", b), d, 16'h0100 | 16'(b));
        end
        bus_rd(4'h2, d);  check("t6_stat_end", d, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
